// File: rtl/spart_pkg.sv
// spart_pkg
//   Shared definitions for the SPART processor-side bus sequencer.
//   - SPART_ADDR_* : ioaddr register selects on the spart bus
//   - spart_ctrl_state_t : sequencer states, also exported for debug
package spart_pkg;

    localparam logic [1:0] SPART_ADDR_DATA   = 2'b00;
    localparam logic [1:0] SPART_ADDR_STATUS = 2'b01;
    localparam logic [1:0] SPART_ADDR_DB_LO  = 2'b10;
    localparam logic [1:0] SPART_ADDR_DB_HI  = 2'b11;

    typedef enum logic [2:0] {
        CFG_LO,
        CFG_HI,
        IDLE,
        RD,
        WR,
        GUARD
    } spart_ctrl_state_t;

    // States whose bus cycle is issued on the following clock.
    function automatic logic is_bus_state(input spart_ctrl_state_t s);
        return (s == CFG_LO) || (s == CFG_HI) || (s == RD) || (s == WR);
    endfunction

endpackage

// File: rtl/spart_bus_ctrl.sv
// spart_bus_ctrl
//   Owns the spart processor-side bus. After reset it writes the baud divisor
//   (DB_LO then DB_HI), then shares the single databus between a TX byte stream
//   and an RX byte stream. rda/tbr pins are the only status source; STATUS is
//   never read.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   cfg_start/cfg_div   request divisor reprogramming (accepted only in IDLE)
//   cfg_done            divisor programmed; low while (re)programming
//   tx_valid/tx_data    byte to transmit; tx_ready pulses on acceptance
//   rx_valid/rx_data    received byte holding register; rx_ready consumes it
//   iocs/iorw/ioaddr    registered spart bus controls
//   databus             bidirectional spart data bus (driven only on writes)
//   rda/tbr             spart receive-available / transmit-buffer-ready pins
//   dbg_state           current sequencer state
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready.
//   TX: tx_ready is high only in a cycle where tx_data is taken, so the
//   client drops or changes tx_data after that edge. RX: rx_valid stays high
//   with rx_data stable until an edge sees rx_valid && rx_ready.
//
// Timing: the state decides the access; the bus registers present it during
//   the next clock. A read is therefore sampled at the end of the cycle in
//   which iocs && iorw is visible on the pins.
module spart_bus_ctrl
    import spart_pkg::*;
#(
    parameter logic [15:0] DIV_RESET = 16'h028B,
    parameter int          GUARD_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_start,
    input  logic [15:0]       cfg_div,
    output logic              cfg_done,
    input  logic              tx_valid,
    input  logic [7:0]        tx_data,
    output logic              tx_ready,
    output logic              rx_valid,
    output logic [7:0]        rx_data,
    input  logic              rx_ready,
    output logic              iocs,
    output logic              iorw,
    output logic [1:0]        ioaddr,
    inout  wire  [7:0]        databus,
    input  logic              rda,
    input  logic              tbr,
    output spart_ctrl_state_t dbg_state
);

    localparam int GW = (GUARD_CYC < 1) ? 1 : $clog2(GUARD_CYC + 1);
    localparam logic [GW-1:0] GUARD_LAST = GW'((GUARD_CYC < 1) ? 0 : GUARD_CYC - 1);

    spart_ctrl_state_t state, next_state;
    logic [15:0]       div_q;
    logic [7:0]        wr_q;
    logic [GW-1:0]     guard_cnt;
    logic              take_cfg;

    logic              bus_cs_d;
    logic              bus_rw_d;
    logic [1:0]        bus_addr_d;
    logic              rd_done;
    logic              cfg_hi_done;

    // ------------------------------------------------------------------
    // Next-state and handshake decode
    // ------------------------------------------------------------------
    always_comb begin
        next_state = state;
        tx_ready   = 1'b0;
        take_cfg   = 1'b0;
        unique case (state)
            CFG_LO: next_state = CFG_HI;
            CFG_HI: next_state = IDLE;
            IDLE: begin
                if (cfg_start) begin
                    take_cfg   = 1'b1;
                    next_state = CFG_LO;
                end else if (rda && !rx_valid) begin
                    // Drain RX before TX so the spart receiver cannot overrun.
                    next_state = RD;
                end else if (tx_valid && tbr) begin
                    tx_ready   = 1'b1;
                    next_state = WR;
                end
            end
            RD:    next_state = GUARD;
            WR:    next_state = GUARD;
            GUARD: if (guard_cnt == GUARD_LAST) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Bus cycle requested by the current state, registered onto the pins.
    always_comb begin
        bus_cs_d   = is_bus_state(state);
        bus_rw_d   = 1'b1;
        bus_addr_d = SPART_ADDR_DATA;
        unique case (state)
            CFG_LO: begin bus_rw_d = 1'b0; bus_addr_d = SPART_ADDR_DB_LO; end
            CFG_HI: begin bus_rw_d = 1'b0; bus_addr_d = SPART_ADDR_DB_HI; end
            WR:     bus_rw_d = 1'b0;
            default: ;
        endcase
    end

    assign rd_done     = iocs && iorw && (ioaddr == SPART_ADDR_DATA);
    assign cfg_hi_done = iocs && !iorw && (ioaddr == SPART_ADDR_DB_HI);

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= CFG_LO;
            guard_cnt <= '0;
            div_q     <= DIV_RESET;
            wr_q      <= 8'h00;
            iocs      <= 1'b0;
            iorw      <= 1'b1;
            ioaddr    <= SPART_ADDR_DATA;
            cfg_done  <= 1'b0;
            rx_valid  <= 1'b0;
            rx_data   <= 8'h00;
        end else begin
            state  <= next_state;
            iocs   <= bus_cs_d;
            iorw   <= bus_rw_d;
            ioaddr <= bus_addr_d;

            if (state == GUARD) guard_cnt <= guard_cnt + 1'b1;
            else                guard_cnt <= '0;

            if (take_cfg) div_q <= cfg_div;

            // wr_q is loaded on the edge before its bus cycle appears.
            if (tx_ready)             wr_q <= tx_data;
            else if (state == CFG_LO) wr_q <= div_q[7:0];
            else if (state == CFG_HI) wr_q <= div_q[15:8];

            if (take_cfg)         cfg_done <= 1'b0;
            else if (cfg_hi_done) cfg_done <= 1'b1;

            if (rd_done) begin
                rx_data  <= databus;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

    // Floats immediately on reset because iocs/iorw reset asynchronously.
    assign databus   = (iocs && !iorw) ? wr_q : 8'bzzzz_zzzz;
    assign dbg_state = state;

endmodule
